// File: rtl/sram_responder_if.sv
// SLC-3 active-low SRAM control bus between the CPU (master) and the
// memory responder (slave).
interface sram_responder_if #(
    parameter int ADDR_W = 20
);
    logic              Mem_CE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic              Mem_OE;
    logic              Mem_WE;
    logic [ADDR_W-1:0] ADDR;
    logic [15:0]       Data_to_mem;
    logic [15:0]       Data_from_mem;
    logic              Data_valid;
    logic              Busy;

    modport master (
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_mem,
        input  Data_from_mem, Data_valid, Busy
    );

    modport slave (
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_mem,
        output Data_from_mem, Data_valid, Busy
    );
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for the SLC-3 external SRAM. Services CPU reads/writes
// from an internal word array and maps one address onto the board I/O
// (Switches on read, HEX_reg on write).
module sram_responder #(
    parameter int          ADDR_W     = 20,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          READ_WAIT  = 1,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sram_responder_if.slave       bus,
    input  logic [15:0]           Switches,
    output logic [15:0]           HEX_reg
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_HOLD,
        WR_ACTIVE,
        WR_COMMIT
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT - 1);

    // Array contents deliberately have no reset.
    logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [15:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [15:0]       hex_q, hex_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]       wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              wr_ub_q, wr_ub_d;
    logic              wr_lb_q, wr_lb_d;

    logic              req_wr, req_rd, addr_changed, rd_io, wr_io;
    logic              go_rd, go_wr;
    logic [15:0]       rd_word;

    // Active-low byte enables: a low enable takes the new byte.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_w,
                                                input logic [15:0] new_w,
                                                input logic        ub_n,
                                                input logic        lb_n);
        merge_bytes[15:8] = ub_n ? old_w[15:8] : new_w[15:8];
        merge_bytes[7:0]  = lb_n ? old_w[7:0]  : new_w[7:0];
    endfunction

    // Bus request decode; a write wins over a simultaneous OE-low.
    always_comb begin
        req_wr       = !bus.Mem_CE && !bus.Mem_WE;
        req_rd       = !bus.Mem_CE && !bus.Mem_OE && bus.Mem_WE;
        addr_changed = bus.ADDR != rd_addr_q;
        rd_io        = rd_addr_q[15:0] == IO_ADDR;
        wr_io        = wr_addr_q == IO_ADDR;
        rd_word      = rd_io ? Switches : mem[rd_addr_q[DEPTH_LOG2-1:0]];
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        hex_d     = hex_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_ub_d   = wr_ub_q;
        wr_lb_d   = wr_lb_q;
        go_rd     = 1'b0;
        go_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_wr)      go_wr = 1'b1;
                else if (req_rd) go_rd = 1'b1;
            end
            RD_WAIT: begin
                if (req_wr)            go_wr = 1'b1;
                else if (!req_rd)      state_d = IDLE;
                else if (addr_changed) go_rd = 1'b1;
                else if (cnt_q == 3'd0) begin
                    data_d  = rd_word;
                    valid_d = 1'b1;
                    state_d = RD_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RD_HOLD: begin
                if (req_wr)            go_wr = 1'b1;
                else if (!req_rd)      state_d = IDLE;
                else if (addr_changed) go_rd = 1'b1;
                else                   valid_d = 1'b1;
            end
            WR_ACTIVE: begin
                if (req_wr) begin
                    go_wr = 1'b1;
                end else begin
                    state_d = WR_COMMIT;
                    busy_d  = 1'b1;
                end
            end
            WR_COMMIT: begin
                // The array commit happens on this same edge, so a read
                // started here registers post-commit contents later.
                if (wr_io) hex_d = merge_bytes(hex_q, wr_data_q, wr_ub_q, wr_lb_q);
                if (req_rd) go_rd = 1'b1;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (go_wr) begin
            state_d   = WR_ACTIVE;
            wr_addr_d = bus.ADDR[15:0];
            wr_data_d = bus.Data_to_mem;
            wr_ub_d   = bus.Mem_UB;
            wr_lb_d   = bus.Mem_LB;
        end
        if (go_rd) begin
            state_d   = RD_WAIT;
            cnt_d     = WAIT_INIT;
            rd_addr_d = bus.ADDR;
        end
    end

    // Control state and registered outputs, asynchronously reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            hex_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            hex_q   <= hex_d;
        end
    end

    // Latched access address/data; meaningless until a request latches them.
    always_ff @(posedge Clk) begin
        rd_addr_q <= rd_addr_d;
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
        wr_ub_q   <= wr_ub_d;
        wr_lb_q   <= wr_lb_d;
    end

    // Byte-wise array commit; the I/O word never reaches the array.
    always_ff @(posedge Clk) begin
        if (state_q == WR_COMMIT && !wr_io) begin
            if (!wr_lb_q) mem[wr_addr_q[DEPTH_LOG2-1:0]][7:0]  <= wr_data_q[7:0];
            if (!wr_ub_q) mem[wr_addr_q[DEPTH_LOG2-1:0]][15:8] <= wr_data_q[15:8];
        end
    end

    assign bus.Data_from_mem = data_q;
    assign bus.Data_valid    = valid_q;
    assign bus.Busy          = busy_q;
    assign HEX_reg           = hex_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios followed by a
// randomized mix of reads and writes checked against a word-array model.
module tb_sram_responder;

    localparam int READ_WAIT = 1;

    logic        Clk;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] HEX_reg;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mm [0:1023];
    logic [15:0] hex_m;
    logic [15:0] last_rd;
    logic [9:0]  pool [8] = '{10'h000, 10'h010, 10'h011, 10'h020,
                              10'h040, 10'h3FF, 10'h155, 10'h2AA};
    logic [15:0] obs;

    sram_responder_if #(.ADDR_W(20)) bus ();

    sram_responder #(
        .ADDR_W     (20),
        .DEPTH_LOG2 (10),
        .READ_WAIT  (READ_WAIT),
        .IO_ADDR    (16'hFFFF)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .bus      (bus.slave),
        .Switches (Switches),
        .HEX_reg  (HEX_reg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.Mem_CE = 1'b1;
        bus.Mem_OE = 1'b1;
        bus.Mem_WE = 1'b1;
        bus.Mem_UB = 1'b1;
        bus.Mem_LB = 1'b1;
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic ub_n, input logic lb_n);
        logic [15:0] r;
        r = old_w;
        if (!ub_n) r = (r & 16'h00FF) | (new_w & 16'hFF00);
        if (!lb_n) r = (r & 16'hFF00) | (new_w & 16'h00FF);
        return r;
    endfunction

    function automatic logic [19:0] rand_addr(input int idx);
        logic [9:0] up;
        up = 10'($urandom) & 10'b1111011111;
        return {up, pool[idx]};
    endfunction

    function automatic bit is_io(input logic [19:0] a);
        return a[15:0] == 16'hFFFF;
    endfunction

    task automatic model_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
        if (is_io(a)) hex_m = merge(hex_m, d, ub, lb);
        else          mm[a[9:0]] = merge(mm[a[9:0]], d, ub, lb);
    endtask

    // Write with 'beats' WE-low cycles; only the final beat carries the target.
    task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                            input logic ub, input logic lb, input int beats);
        for (int b = 0; b < beats; b++) begin
            bus.Mem_CE = 1'b0;
            bus.Mem_WE = 1'b0;
            bus.Mem_OE = 1'($urandom);
            if (b == beats - 1) begin
                bus.ADDR = a; bus.Data_to_mem = d; bus.Mem_UB = ub; bus.Mem_LB = lb;
            end else begin
                bus.ADDR = rand_addr(int'($urandom_range(0, 7)));
                bus.Data_to_mem = 16'($urandom);
                bus.Mem_UB = 1'($urandom);
                bus.Mem_LB = 1'($urandom);
            end
            tick();
            check("wr_busy_active", bus.Busy, 1'b0);
        end
        idle_bus();
        tick();
        check("wr_busy_commit", bus.Busy, 1'b1);
        model_write(a, d, ub, lb);
        tick();
        check("wr_busy_done", bus.Busy, 1'b0);
        check("wr_hex", HEX_reg, hex_m);
    endtask

    // Read with extra hold cycles; I/O reads change Switches before the
    // registering edge to confirm the sample point.
    task automatic do_read(input logic [19:0] a, input int hold, output logic [15:0] got);
        logic [15:0] exp_d;
        bus.Mem_CE = 1'b0;
        bus.Mem_OE = 1'b0;
        bus.Mem_WE = 1'b1;
        bus.ADDR   = a;
        tick();
        check("rd_wait_valid", bus.Data_valid, 1'b0);
        if (is_io(a)) begin
            Switches = 16'($urandom);
            exp_d = Switches;
        end else begin
            exp_d = mm[a[9:0]];
        end
        for (int i = 1; i < READ_WAIT; i++) begin
            tick();
            check("rd_wait_valid_n", bus.Data_valid, 1'b0);
        end
        tick();
        check("rd_valid", bus.Data_valid, 1'b1);
        check("rd_data", bus.Data_from_mem, exp_d);
        got = bus.Data_from_mem;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rd_hold_valid", bus.Data_valid, 1'b1);
            check("rd_hold_data", bus.Data_from_mem, exp_d);
        end
        idle_bus();
        tick();
        check("rd_end_valid", bus.Data_valid, 1'b0);
        check("rd_end_keep", bus.Data_from_mem, exp_d);
        last_rd = exp_d;
    endtask

    initial begin
        logic [15:0] d;
        logic [19:0] a;
        Reset = 1'b0;
        Switches = 16'h0000;
        bus.ADDR = 20'h0;
        bus.Data_to_mem = 16'h0;
        idle_bus();
        hex_m = 16'h0;
        last_rd = 16'h0;

        // Reset state
        repeat (3) tick();
        check("rst_valid", bus.Data_valid, 1'b0);
        check("rst_busy", bus.Busy, 1'b0);
        check("rst_data", bus.Data_from_mem, 16'h0);
        check("rst_hex", HEX_reg, 16'h0);
        Reset = 1'b1;
        repeat (2) tick();
        check("idle_valid_ce_high", bus.Data_valid, 1'b0);

        // Give every pool word a known value
        for (int i = 0; i < 8; i++)
            do_write({10'h000, pool[i]}, 16'($urandom), 1'b0, 1'b0, 1);

        // Basic read of 0x3000
        do_write(20'h03000, 16'h1234, 1'b0, 1'b0, 1);
        do_read(20'h03000, 1, obs);
        check("rd_3000_const", obs, 16'h1234);

        // Lower-byte-only write keeps old upper byte
        do_write(20'h00040, 16'h0000, 1'b0, 1'b0, 1);
        do_write(20'h00040, 16'hABCD, 1'b1, 1'b0, 2);
        do_read(20'h00040, 0, obs);
        check("rd_partial_const", obs, 16'h00CD);

        // I/O write to HEX_reg leaves array[0x3FF] untouched; I/O read
        do_write(20'h0FFFF, 16'h5A5A, 1'b0, 1'b0, 1);
        check("hex_const", HEX_reg, 16'h5A5A);
        do_read(20'h003FF, 0, obs);
        bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b1; bus.ADDR = 20'h0FFFF;
        Switches = 16'h1111;
        tick();
        Switches = 16'h0F0F;
        for (int i = 1; i < READ_WAIT; i++) tick();
        tick();
        check("io_rd_switches", bus.Data_from_mem, 16'h0F0F);
        check("io_rd_valid", bus.Data_valid, 1'b1);
        idle_bus();
        tick();
        last_rd = 16'h0F0F;

        // Address change during an ongoing read restarts the wait
        bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b1; bus.ADDR = 20'h00010;
        for (int i = 0; i <= READ_WAIT; i++) tick();
        check("chg_first_valid", bus.Data_valid, 1'b1);
        check("chg_first_data", bus.Data_from_mem, mm[10'h010]);
        bus.ADDR = 20'h00011;
        for (int i = 0; i < READ_WAIT; i++) begin
            tick();
            check("chg_valid_drop", bus.Data_valid, 1'b0);
        end
        tick();
        check("chg_second_valid", bus.Data_valid, 1'b1);
        check("chg_second_data", bus.Data_from_mem, mm[10'h011]);
        last_rd = mm[10'h011];
        idle_bus();
        tick();

        // CE high aborts a pending read
        bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b1; bus.ADDR = 20'h002AA;
        tick();
        bus.Mem_CE = 1'b1;
        tick();
        check("abort_valid", bus.Data_valid, 1'b0);
        tick();
        check("abort_valid2", bus.Data_valid, 1'b0);
        check("abort_keep", bus.Data_from_mem, last_rd);

        // Read issued during the commit cycle sees the new data
        d = 16'($urandom);
        bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0; bus.Mem_OE = 1'b1;
        bus.ADDR = 20'h00155; bus.Data_to_mem = d; bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
        tick();
        bus.Mem_WE = 1'b1; bus.Mem_OE = 1'b0;
        tick();
        check("raw_busy", bus.Busy, 1'b1);
        model_write(20'h00155, d, 1'b0, 1'b0);
        tick();
        check("raw_busy_off", bus.Busy, 1'b0);
        for (int i = 1; i < READ_WAIT; i++) tick();
        tick();
        check("raw_valid", bus.Data_valid, 1'b1);
        check("raw_data", bus.Data_from_mem, d);
        last_rd = d;
        idle_bus();
        tick();

        // Reset during WR_ACTIVE discards the write
        bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
        bus.ADDR = 20'h00020; bus.Data_to_mem = ~mm[10'h020]; bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
        tick();
        tick();
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_busy", bus.Busy, 1'b0);
        check("mid_rst_hex", HEX_reg, 16'h0);
        check("mid_rst_data", bus.Data_from_mem, 16'h0);
        hex_m = 16'h0;
        idle_bus();
        tick();
        Reset = 1'b1;
        tick();
        do_read(20'h00020, 0, obs);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) a = {4'($urandom), 16'hFFFF};
            else a = rand_addr(int'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1)
                do_write(a, 16'($urandom), 1'($urandom), 1'($urandom),
                         int'($urandom_range(1, 3)));
            else
                do_read(a, int'($urandom_range(0, 2)), obs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SLC-3 CPU's active-low SRAM control bus (Mem_CE/UB/LB/OE/WE).
- Services the read and write accesses that the CPU control unit initiates. Backs them with an on-chip word array.
- Decodes a memory-mapped I/O word: switches on read, hex-display register on write.
- Replaces the off-chip SRAM for simulation and small FPGA builds.
- Read latency matches the CPU's fixed two-cycle fetch: data must be valid in the second OE-low cycle.

Parameters:
- ADDR_W, 20, width of ADDR bus.
- DEPTH_LOG2, 10, log2 of internal array words. Upper address bits are ignored (aliasing).
- READ_WAIT, 1, clock edges from first sampled OE-low cycle until Data_from_mem is valid. Legal range 1..7.
- IO_ADDR, 16'hFFFF, address (low 16 bits compared, upper bits ignored) of the I/O word.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Mem_CE  in  1  chip enable, active low.
- Mem_UB  in  1  upper byte enable, active low.
- Mem_LB  in  1  lower byte enable, active low.
- Mem_OE  in  1  output enable, active low.
- Mem_WE  in  1  write enable, active low.
- ADDR  in  ADDR_W  word address.
- Data_to_mem  in  16  write data from CPU.
- Data_from_mem  out  16  read data to CPU MDR.
- Data_valid  out  1  Data_from_mem holds valid data for the current read address.
- Switches  in  16  board switches, returned on I/O read.
- HEX_reg  out  16  I/O write register driving the hex displays.
- Busy  out  1  write commit in progress.

Behaviour:
- Reset asserted (low), asynchronous:
  - state=IDLE; Data_from_mem=0; Data_valid=0; HEX_reg=0; Busy=0; wait counter=0.
  - Array contents are not cleared.
- Request decode (sampled each rising edge):
  - Write = CE=0 & WE=0. Write wins if OE is also low.
  - Read = CE=0 & OE=0 & WE=1.
  - Otherwise no request.
- States:
  - IDLE
    - Read → RD_WAIT: latch address; counter=READ_WAIT-1.
    - Write → WR_ACTIVE: latch addr/data/byte enables.
  - RD_WAIT
    - Each edge: counter decrements.
    - At counter=0: register the word (array or Switches) into Data_from_mem; Data_valid=1; go to RD_HOLD.
    - With READ_WAIT=1, RD_WAIT lasts one cycle, so the data is valid in the 2nd OE-low cycle.
  - RD_HOLD
    - Data_valid stays 1 while the read persists with an unchanged address.
    - Address change while reading → Data_valid=0, re-enter RD_WAIT (full wait restarts).
    - Request ends → IDLE, Data_valid=0, Data_from_mem keeps its last value.
    - Write request → WR_ACTIVE.
  - WR_ACTIVE
    - Every WE-low cycle re-latches ADDR, Data_to_mem, UB, LB. The last-latched values win.
    - When WE or CE goes high → WR_COMMIT.
  - WR_COMMIT (exactly one cycle)
    - Busy=1.
    - Write latched bytes: LB=0 → bits 7:0, UB=0 → bits 15:8. Both high → no bytes changed, state still transitions.
    - Next state: IDLE, or RD_WAIT if a read is sampled in this cycle. That read uses the post-commit contents (read-after-write coherent).
- I/O decode:
  - ADDR[15:0]==IO_ADDR → read returns Switches as sampled on the registering edge.
  - A write at that address updates HEX_reg per byte enables and never touches the array.
- Array writes occur only in WR_COMMIT. Reads never modify state other than Data_from_mem/Data_valid.
- CE high aborts a pending read immediately → IDLE, Data_valid=0.
- Reset mid-write (before WR_COMMIT) → no array or HEX_reg update.

Test Plan:
- Reset low, then release → all outputs 0, state IDLE. Data_valid stays 0 with CE=1.
- Preload array[0x3000]=0x1234 by backdoor; CE=0, OE=0, ADDR=0x3000 for 2 cycles → Data_valid=1 and Data_from_mem=0x1234 in cycle 2.
- Write 0xABCD to 0x0040 with UB=1, LB=0; then read 0x0040 → returns 0x00CD (old upper byte 0x00 kept). Busy=1 for exactly one cycle after WE rises.
- Write 0x5A5A to IO_ADDR → HEX_reg=0x5A5A and array[0x3FF] unchanged. With Switches=0x0F0F, read IO_ADDR → 0x0F0F.
- Read 0x0010, then change ADDR to 0x0011 while OE stays low → Data_valid drops for READ_WAIT cycles, then shows array[0x0011].
- Assert Reset during WR_ACTIVE of a write to 0x0020 → after release, read 0x0020 returns its pre-write value.
